// File: rtl/store_monitor.sv
// Store-bus monitor: logs memory-stage stores into a show-ahead FIFO,
// detects the tohost completion write and runs a hang watchdog.
module store_monitor #(
    parameter int unsigned DEPTH       = 8,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_00FC,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic [31:0] data_addr_m,
    input  logic [31:0] write_data_m,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic [31:0] store_count,
    output logic [15:0] drop_count,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

    state_t      state;
    logic [31:0] mem_addr [DEPTH];
    logic [31:0] mem_data [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [WW-1:0] wd;

    logic push, pop, full, do_write, tohost, head_bypass, wd_hit;

    always_comb begin
        push        = mem_write && (state == S_RUN);
        pop         = log_valid && log_ready;
        full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_write    = push && (!full || pop);
        wr_ptr_n    = wr_ptr + {{AW{1'b0}}, do_write};
        rd_ptr_n    = rd_ptr + {{AW{1'b0}}, pop};
        tohost      = push && (data_addr_m == TOHOST_ADDR) && write_data_m[0];
        // The entry being written lands at the new head only when the FIFO
        // would otherwise be empty next cycle, so forward it directly.
        head_bypass = do_write && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0]);
        wd_hit      = (wd == WW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_addr[wr_ptr[AW-1:0]] <= data_addr_m;
            mem_data[wr_ptr[AW-1:0]] <= write_data_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            log_valid   <= 1'b0;
            log_addr    <= '0;
            log_data    <= '0;
            store_count <= '0;
            drop_count  <= '0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            log_valid <= (wr_ptr_n != rd_ptr_n);
            log_addr  <= head_bypass ? data_addr_m  : mem_addr[rd_ptr_n[AW-1:0]];
            log_data  <= head_bypass ? write_data_m : mem_data[rd_ptr_n[AW-1:0]];
            if (push) begin
                store_count <= store_count + 32'd1;
                if (!do_write && (drop_count != '1))
                    drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_RUN;
            wd        <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= '0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    wd <= wd + 1'b1;
                    if (tohost) begin
                        done <= 1'b1;
                        if (write_data_m == 32'd1) begin
                            state <= S_PASS;
                            pass  <= 1'b1;
                        end else begin
                            state     <= S_FAIL;
                            fail_code <= write_data_m[31:1];
                        end
                    end else if (wd_hit) begin
                        state   <= S_TIMEOUT;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor: FIFO ordering/overflow, tohost pass/fail, watchdog.
module tb_store_monitor;

    logic        clk;
    logic        rst;
    logic        mem_write;
    logic [31:0] data_addr_m;
    logic [31:0] write_data_m;
    logic        log_ready;
    logic        log_valid;
    logic [31:0] log_addr, log_data, store_count;
    logic [15:0] drop_count;
    logic        done, pass, timeout;
    logic [30:0] fail_code;

    logic        w_mem_write, w_log_ready, w_log_valid, w_done, w_pass, w_timeout;
    logic [31:0] w_addr, w_wdata, w_log_addr, w_log_data, w_store_count;
    logic [15:0] w_drop_count;
    logic [30:0] w_fail_code;

    int checks = 0;
    int errors = 0;

    store_monitor u_dut (
        .clk(clk), .rst(rst), .mem_write(mem_write), .data_addr_m(data_addr_m),
        .write_data_m(write_data_m), .log_valid(log_valid), .log_ready(log_ready),
        .log_addr(log_addr), .log_data(log_data), .store_count(store_count),
        .drop_count(drop_count), .done(done), .pass(pass), .fail_code(fail_code),
        .timeout(timeout)
    );

    store_monitor #(.TIMEOUT(20)) u_wd (
        .clk(clk), .rst(rst), .mem_write(w_mem_write), .data_addr_m(w_addr),
        .write_data_m(w_wdata), .log_valid(w_log_valid), .log_ready(w_log_ready),
        .log_addr(w_log_addr), .log_data(w_log_data), .store_count(w_store_count),
        .drop_count(w_drop_count), .done(w_done), .pass(w_pass), .fail_code(w_fail_code),
        .timeout(w_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_write    = 1'b1;
        data_addr_m  = a;
        write_data_m = d;
        step();
        mem_write    = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; mem_write = 1'b0; data_addr_m = '0; write_data_m = '0; log_ready = 1'b0;
        w_mem_write = 1'b0; w_addr = '0; w_wdata = '0; w_log_ready = 1'b0;
        step();

        // Reset during active stores
        mem_write = 1'b1; data_addr_m = 32'h40; write_data_m = 32'h99;
        rst = 1'b0;
        step(); step();
        rst = 1'b1; mem_write = 1'b0;
        check("rst_valid", log_valid, 0);
        check("rst_addr", log_addr, 0);
        check("rst_data", log_data, 0);
        check("rst_store_count", store_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail_code", fail_code, 0);
        check("rst_timeout", timeout, 0);
        step();
        check("rst_no_entry", log_valid, 0);
        check("rst_no_count", store_count, 0);

        // Three stores streamed with ready high
        do_reset(1);
        log_ready = 1'b1;
        store(32'h10, 32'hA);
        check("s3_v0", log_valid, 1); check("s3_a0", log_addr, 32'h10); check("s3_d0", log_data, 32'hA);
        store(32'h14, 32'hB);
        check("s3_v1", log_valid, 1); check("s3_a1", log_addr, 32'h14); check("s3_d1", log_data, 32'hB);
        store(32'h18, 32'hC);
        check("s3_v2", log_valid, 1); check("s3_a2", log_addr, 32'h18); check("s3_d2", log_data, 32'hC);
        step();
        check("s3_empty", log_valid, 0);
        check("s3_count", store_count, 3);

        // Overflow: DEPTH+3 stores with ready low
        do_reset(1);
        log_ready = 1'b0;
        for (int i = 0; i < 11; i++) store(32'h100 + 32'(4 * i), 32'(i + 1));
        check("ovf_store_count", store_count, 11);
        check("ovf_drop_count", drop_count, 3);
        check("ovf_valid", log_valid, 1);
        log_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_valid", log_valid, 1);
            check("ovf_drain_addr", log_addr, 32'h100 + 32'(4 * i));
            check("ovf_drain_data", log_data, 32'(i + 1));
            step();
        end
        check("ovf_drained", log_valid, 0);

        // Full FIFO, simultaneous push and pop
        do_reset(1);
        log_ready = 1'b0;
        for (int i = 0; i < 8; i++) store(32'h200 + 32'(4 * i), 32'h100 + 32'(i));
        log_ready = 1'b1;
        store(32'h20, 32'h55);
        check("pp_drop_count", drop_count, 0);
        check("pp_store_count", store_count, 9);
        for (int i = 0; i < 8; i++) begin
            check("pp_drain_valid", log_valid, 1);
            check("pp_drain_addr", log_addr, (i < 7) ? 32'h200 + 32'(4 * (i + 1)) : 32'h20);
            check("pp_drain_data", log_data, (i < 7) ? 32'h100 + 32'(i + 1) : 32'h55);
            step();
        end
        check("pp_drained", log_valid, 0);

        // tohost pass
        do_reset(1);
        log_ready = 1'b0;
        store(32'hFC, 32'h1);
        check("pass_done", done, 1);
        check("pass_pass", pass, 1);
        check("pass_timeout", timeout, 0);
        check("pass_fail_code", fail_code, 0);
        check("pass_logged_valid", log_valid, 1);
        check("pass_logged_addr", log_addr, 32'hFC);
        check("pass_logged_data", log_data, 32'h1);
        store(32'h30, 32'h77);
        check("pass_frozen_count", store_count, 1);
        log_ready = 1'b1;
        step();
        check("pass_no_late_entry", log_valid, 0);
        check("pass_sticky", pass, 1);

        // tohost fail
        do_reset(1);
        log_ready = 1'b0;
        store(32'hFC, 32'h7);
        check("fail_done", done, 1);
        check("fail_pass", pass, 0);
        check("fail_code", fail_code, 3);
        check("fail_timeout", timeout, 0);

        // tohost with bit0 clear is ordinary
        do_reset(1);
        store(32'hFC, 32'h4);
        check("even_done", done, 0);
        check("even_pass", pass, 0);
        check("even_count", store_count, 1);
        check("even_logged", log_valid, 1);
        store(32'h10, 32'h5);
        check("even_count2", store_count, 2);
        check("even_done2", done, 0);

        // Watchdog with TIMEOUT=20
        do_reset(1);
        check("wd_start", w_timeout, 0);
        repeat (19) step();
        check("wd_19_timeout", w_timeout, 0);
        check("wd_19_done", w_done, 0);
        step();
        check("wd_20_timeout", w_timeout, 1);
        check("wd_20_done", w_done, 1);
        check("wd_20_pass", w_pass, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
